// File: rtl/pi_op_queue_if.sv
// Downstream operation handshake between the Pi op queue and the bus sequencer.
// master: queue side (drives head fields); slave: sequencer side (drives ack/done/read data).
`timescale 1ns/1ps
interface pi_op_if;
  logic        OP_VALID;
  logic        OP_RW;
  logic        OP_UDS_n;
  logic        OP_LDS_n;
  logic [23:0] OP_ADDR;
  logic [15:0] OP_WDATA;
  logic        OP_ACK;
  logic        OP_DONE;
  logic [15:0] OP_RDATA;
  logic        OP_BERR;

  modport master (
    output OP_VALID, OP_RW, OP_UDS_n, OP_LDS_n, OP_ADDR, OP_WDATA,
    input  OP_ACK, OP_DONE, OP_RDATA, OP_BERR
  );

  modport slave (
    input  OP_VALID, OP_RW, OP_UDS_n, OP_LDS_n, OP_ADDR, OP_WDATA,
    output OP_ACK, OP_DONE, OP_RDATA, OP_BERR
  );
endinterface

// File: rtl/pi_op_queue.sv
// Pi-facing op queue: captures Pi register writes into bus ops, FIFOs them to the sequencer.
// Ports: PI_CLK/PI_RST_n, Pi GPIO bus (PI_A/RD/WR/D_IN/D_OUT/D_OE/TXN), op (pi_op_if.master).
// Optional: define PI_QUEUE_BERR_EN to make a bus error set err and flush the queue.
`timescale 1ns/1ps
module pi_op_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        PI_CLK,
  input  logic        PI_RST_n,
  input  logic [1:0]  PI_A,
  input  logic        PI_RD,
  input  logic        PI_WR,
  input  logic [15:0] PI_D_IN,
  output logic [15:0] PI_D_OUT,
  output logic        PI_D_OE,
  output logic        PI_TXN_IN_PROGRESS,
  pi_op_if.master     op
);

  localparam int CNT_W = PTR_W + 1;
`ifdef PI_QUEUE_BERR_EN
  localparam bit BERR_EN = 1'b1;
`else
  localparam bit BERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [23:0] addr;
    logic [15:0] wdata;
  } op_t;

  op_t              mem [DEPTH];
  op_t              entry;
  op_t              head;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             outstanding;
  logic             last_rw;
  logic [15:0]      rdata;
  logic             rd_valid;
  logic             ovf;
  logic             err;
  logic [15:0]      wdata_stage;
  logic [15:0]      addr_lo;
  logic [2:0]       rd_sy, wr_sy;

  // [0],[1] synchroniser, [2] previous synchronised value
  logic rd_rise, wr_rise;
  assign rd_rise = rd_sy[1] & ~rd_sy[2];
  assign wr_rise = wr_sy[1] & ~wr_sy[2];

  logic a_data, a_lo, a_hi, a_stat;
  assign a_data = PI_A == 2'd0;
  assign a_lo   = PI_A == 2'd1;
  assign a_hi   = PI_A == 2'd2;
  assign a_stat = PI_A == 2'd3;

  logic full, commit, pop, done, flush, push, clr;
  assign full   = count == CNT_W'(DEPTH);
  assign commit = wr_rise & a_hi;
  assign pop    = op.OP_ACK & op.OP_VALID;
  assign done   = op.OP_DONE & outstanding;
  assign flush  = done & op.OP_BERR & BERR_EN;
  // A same-cycle pop frees the slot before the push lands
  assign push   = commit & (~full | pop) & ~flush;
  assign clr    = wr_rise & a_stat & PI_D_IN[15];

  logic [15:0] status;
  assign status = {ovf, err, rd_valid, PI_TXN_IN_PROGRESS,
                   8'd0, 4'(count)};

  always_comb begin
    entry       = '0;
    entry.rw    = PI_D_IN[9];
    entry.addr  = {PI_D_IN[7:0], addr_lo};
    entry.wdata = wdata_stage;
    entry.uds_n = PI_D_IN[8] &  addr_lo[0];
    entry.lds_n = PI_D_IN[8] & ~addr_lo[0];
  end

  assign head        = mem[rd_ptr];
  assign op.OP_VALID = (count != '0) & ~outstanding;
  assign op.OP_RW    = head.rw;
  assign op.OP_UDS_n = head.uds_n;
  assign op.OP_LDS_n = head.lds_n;
  assign op.OP_ADDR  = head.addr;
  assign op.OP_WDATA = head.wdata;

  assign PI_D_OE = rd_sy[1] & (a_data | a_stat);

  always_ff @(posedge PI_CLK) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge PI_CLK or negedge PI_RST_n) begin
    if (!PI_RST_n) begin
      rd_sy              <= '0;
      wr_sy              <= '0;
      rd_ptr             <= '0;
      wr_ptr             <= '0;
      count              <= '0;
      outstanding        <= 1'b0;
      last_rw            <= 1'b0;
      rdata              <= '0;
      rd_valid           <= 1'b0;
      ovf                <= 1'b0;
      err                <= 1'b0;
      wdata_stage        <= '0;
      addr_lo            <= '0;
      PI_D_OUT           <= '0;
      PI_TXN_IN_PROGRESS <= 1'b0;
    end else begin
      rd_sy <= {rd_sy[1:0], PI_RD};
      wr_sy <= {wr_sy[1:0], PI_WR};

      if (wr_rise & a_data) wdata_stage <= PI_D_IN;
      if (wr_rise & a_lo)   addr_lo     <= PI_D_IN;

      if (flush) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end

      if (pop) begin
        outstanding <= 1'b1;
        last_rw     <= head.rw;
      end else if (done) begin
        outstanding <= 1'b0;
      end

      // Completion of a read beats any same-cycle clear
      if (done & last_rw) begin
        rdata    <= flush ? 16'hFFFF : op.OP_RDATA;
        rd_valid <= 1'b1;
      end else if ((rd_rise & a_data) | (push & entry.rw)) begin
        rd_valid <= 1'b0;
      end

      if (clr) ovf <= 1'b0;
      if (commit & full & ~pop & ~flush) ovf <= 1'b1;

      if (clr)   err <= 1'b0;
      if (flush) err <= 1'b1;

      if (rd_rise) begin
        unique case (1'b1)
          a_data:  PI_D_OUT <= rdata;
          a_stat:  PI_D_OUT <= status;
          default: PI_D_OUT <= PI_D_OUT;
        endcase
      end

      PI_TXN_IN_PROGRESS <= (count != '0) | outstanding;
    end
  end

endmodule

// File: tb/tb_pi_op_queue.sv
// Self-checking bench for pi_op_queue: transaction-level queue model plus per-cycle compare.
// Directed Pi register sequences with literal expectations pinning the model.
`timescale 1ns/1ps
module tb_pi_op_queue;
  localparam int DEPTH = 4;
`ifdef PI_QUEUE_BERR_EN
  localparam bit BERR_EN = 1'b1;
`else
  localparam bit BERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pa = '0;
  logic        prd = 1'b0;
  logic        pwr = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        oe;
  logic        txn;

  pi_op_if bus();

  pi_op_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .PI_CLK(clk),
    .PI_RST_n(rst_n),
    .PI_A(pa),
    .PI_RD(prd),
    .PI_WR(pwr),
    .PI_D_IN(din),
    .PI_D_OUT(dout),
    .PI_D_OE(oe),
    .PI_TXN_IN_PROGRESS(txn),
    .op(bus)
  );

  always #2.5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [42:0] m_q[$];
  bit          m_out, m_lastrw, m_rdv, m_ovf, m_err, last_busy;
  logic [15:0] m_rdata, m_wdata, m_alo;

  function automatic bit m_valid();
    return (m_q.size() != 0) && !m_out;
  endfunction

  function automatic bit m_busy();
    return (m_q.size() != 0) || m_out;
  endfunction

  function automatic logic [15:0] m_status();
    logic [3:0] c;
    c = 4'(m_q.size());
    return {m_ovf, m_err, m_rdv, m_busy(), 8'd0, c};
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_out = 0; m_lastrw = 0; m_rdv = 0; m_ovf = 0; m_err = 0;
    m_rdata = '0; m_wdata = '0; m_alo = '0;
  endtask

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [42:0] head_now;
  assign head_now = {bus.OP_RW, bus.OP_UDS_n, bus.OP_LDS_n,
                     bus.OP_ADDR, bus.OP_WDATA};

  always @(negedge clk) begin
    if (rst_n) begin
      check("op_valid", 64'(bus.OP_VALID), 64'(m_valid()));
      if (m_valid()) check("op_head", 64'(head_now), 64'(m_q[0]));
      check("txn", 64'(txn), 64'(last_busy));
      last_busy = m_busy();
    end else begin
      last_busy = 0;
    end
  end

  task automatic m_pop();
    if (m_valid()) begin
      m_lastrw = m_q[0][42];
      void'(m_q.pop_front());
      m_out = 1;
    end
  endtask

  task automatic pi_write(input logic [1:0] a, input logic [15:0] d,
                          input bit ack = 0);
    logic [23:0] ad;
    logic [42:0] e;
    @(posedge clk); #1;
    pa = a; din = d; pwr = 1;
    repeat (2) @(posedge clk);
    #1;
    if (ack) bus.OP_ACK = 1;
    @(posedge clk); #1;
    bus.OP_ACK = 0;
    if (ack) m_pop();
    case (a)
      2'd0: m_wdata = d;
      2'd1: m_alo = d;
      2'd2: begin
        ad = {d[7:0], m_alo};
        e = {d[9], d[8] & ad[0], d[8] & ~ad[0], ad, m_wdata};
        if (m_q.size() == DEPTH) m_ovf = 1;
        else begin
          m_q.push_back(e);
          if (d[9]) m_rdv = 0;
        end
      end
      default: if (d[15]) begin m_ovf = 0; m_err = 0; end
    endcase
    pwr = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic pi_read(input logic [1:0] a, input logic [15:0] exp,
                         input string nm);
    @(posedge clk); #1;
    pa = a; prd = 1;
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_data"}, 64'(dout), 64'(exp));
    check({nm, "_oe"}, 64'(oe), 64'(a == 2'd0 || a == 2'd3));
    if (a == 2'd0) m_rdv = 0;
    prd = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic op_ack();
    @(posedge clk); #1;
    bus.OP_ACK = 1;
    @(posedge clk); #1;
    bus.OP_ACK = 0;
    m_pop();
  endtask

  task automatic op_done(input logic [15:0] rd, input bit be);
    bit fl;
    @(posedge clk); #1;
    bus.OP_DONE = 1; bus.OP_RDATA = rd; bus.OP_BERR = be;
    @(posedge clk); #1;
    bus.OP_DONE = 0; bus.OP_BERR = 0;
    if (m_out) begin
      m_out = 0;
      fl = be && BERR_EN;
      if (fl) begin m_err = 1; m_q.delete(); end
      if (m_lastrw) begin
        m_rdata = fl ? 16'hFFFF : rd;
        m_rdv = 1;
      end
    end
  endtask

  initial begin
    bus.OP_ACK = 0; bus.OP_DONE = 0; bus.OP_RDATA = '0; bus.OP_BERR = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.OP_VALID), 64'd0);
    check("rst_txn", 64'(txn), 64'd0);
    check("rst_oe", 64'(oe), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    rst_n = 1;
    pi_read(2'd3, 16'h0000, "rst_status");

    // word write at 0
    pi_write(2'd0, 16'h1234);
    pi_write(2'd1, 16'h0000);
    pi_write(2'd2, 16'h0000);
    check("w_valid", 64'(bus.OP_VALID), 64'd1);
    check("w_head", 64'(head_now), {21'd0, 3'b000, 24'h0, 16'h1234});
    pi_read(2'd3, 16'h1001, "w_status");
    op_ack();
    op_done(16'h0000, 0);

    // byte read at 0xBFE001
    pi_write(2'd1, 16'hE001);
    pi_write(2'd2, 16'h03BF);
    check("br_head", 64'(head_now[42:16]), {37'd0, 3'b110, 24'hBFE001});
    op_ack();
    op_done(16'h00A5, 0);
    pi_read(2'd3, 16'h2000, "br_status_rdv");
    pi_read(2'd0, 16'h00A5, "br_rdata");
    pi_read(2'd3, 16'h0000, "br_status_clr");

    // overflow: five pushes into four slots
    pi_write(2'd1, 16'h0000);
    for (int i = 0; i < 5; i++) pi_write(2'd2, 16'(i));
    pi_read(2'd3, 16'h9004, "ovf_status");
    pi_read(2'd3, m_status(), "ovf_model");
    pi_write(2'd3, 16'h8000);
    pi_read(2'd3, 16'h1004, "ovf_clr");

    // push and pop together while full
    pi_write(2'd2, 16'h0055, 1);
    pi_read(2'd3, 16'h1004, "pp_status");
    op_done(16'h0000, 0);
    for (int i = 0; i < 3; i++) begin
      op_ack();
      op_done(16'h0000, 0);
    end
    check("pp_valid", 64'(bus.OP_VALID), 64'd1);
    check("pp_addr", 64'(bus.OP_ADDR), 64'h550000);
    op_ack();
    op_done(16'h0000, 0);
    pi_read(2'd3, 16'h0000, "pp_empty");

    // asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) pi_write(2'd2, 16'(16'h10 + i));
    op_ack();
    @(posedge clk); #1;
    rst_n = 0;
    m_reset();
    #0.5;
    check("ar_valid", 64'(bus.OP_VALID), 64'd0);
    check("ar_txn", 64'(txn), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    pi_read(2'd3, 16'h0000, "ar_status");
    check("ar_valid_after", 64'(bus.OP_VALID), 64'd0);

    // bus error on an outstanding read with two more queued
    pi_write(2'd1, 16'h0000);
    pi_write(2'd2, 16'h0200);
    pi_write(2'd2, 16'h0001);
    pi_write(2'd2, 16'h0002);
    op_ack();
    op_done(16'h1111, 1);
    if (BERR_EN) begin
      pi_read(2'd3, 16'h6000, "be_status");
      pi_read(2'd0, 16'hFFFF, "be_rdata");
    end else begin
      pi_read(2'd3, 16'h3002, "be_status");
      pi_read(2'd0, 16'h1111, "be_rdata");
    end
    while (m_q.size() != 0) begin
      op_ack();
      op_done(16'h0000, 0);
    end
    pi_write(2'd3, 16'h8000);
    pi_read(2'd3, m_status(), "final_status");
    check("final_status_lit", 64'(m_status()), 64'd0);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pi_op_queue.md
Name: pi_op_queue

Overview:
- Pi-facing front end of the bus bridge, upstream of the 68k bus sequencer.
- Captures Pi GPIO register writes (data, address lo, address hi/command) into complete bus operations.
- Buffers the operations in a small FIFO and hands them one at a time to the bus sequencer via a valid/ack/done handshake.
- Returns read data and queue status to the Pi.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..8.
PTR_W, 2, log2(DEPTH); pointer width.

Ports:
PI_CLK  in  1  200 MHz Pi-side clock; all logic on posedge.
PI_RST_n  in  1  asynchronous active-low reset.
PI_A  in  2  register select: 0 DATA, 1 ADDR_LO, 2 ADDR_HI, 3 STATUS.
PI_RD  in  1  Pi read strobe, async; synchronised internally.
PI_WR  in  1  Pi write strobe, async; synchronised internally.
PI_D_IN  in  16  Pi data bus input.
PI_D_OUT  out  16  Pi data bus output.
PI_D_OE  out  1  output enable for PI_D_OUT.
PI_TXN_IN_PROGRESS  out  1  queue non-empty or operation outstanding.
OP_VALID  out  1  head operation available to the sequencer.
OP_RW  out  1  1 = read.
OP_UDS_n  out  1  upper data strobe for the head operation.
OP_LDS_n  out  1  lower data strobe for the head operation.
OP_ADDR  out  24  head address.
OP_WDATA  out  16  head write data.
OP_ACK  in  1  one-cycle pulse: sequencer accepted the head.
OP_DONE  in  1  one-cycle pulse: bus cycle finished.
OP_RDATA  in  16  read data; valid with OP_DONE.
OP_BERR  in  1  bus error flag; valid with OP_DONE.

Behaviour:
- Reset (asynchronous, PI_RST_n low):
  - Pointers and count = 0; outstanding = 0; rdata = 0; rd_valid = 0; overflow = 0; err = 0.
  - PI_D_OE = 0, PI_D_OUT = 0, OP_VALID = 0, PI_TXN_IN_PROGRESS = 0.
- Strobe synchronisation:
  - PI_RD and PI_WR each pass through a 2-flop synchroniser.
  - rd_rise / wr_rise = previous synchronised value 0, current 1.
  - All register actions occur on the cycle after the rise is detected.
- Register writes (on wr_rise, decoded by PI_A):
  - DATA: wdata_stage <= PI_D_IN.
  - ADDR_LO: addr_stage[15:0] <= PI_D_IN.
  - ADDR_HI (commits an operation):
    - addr_stage[23:16] <= PI_D_IN[7:0]; byte = PI_D_IN[8]; rw = PI_D_IN[9].
    - Byte operations: UDS_n = addr[0], LDS_n = !addr[0]. Word operations: both strobes 0.
    - Entry pushed = {rw, UDS_n, LDS_n, addr[23:0], wdata_stage}.
    - A read push clears rd_valid.
    - If the FIFO is full: entry dropped, overflow sticky set, count unchanged.
  - STATUS: bit 15 set to 1 clears overflow and err.
- Pi reads:
  - PI_D_OE = synchronised PI_RD && (PI_A==DATA || PI_A==STATUS).
  - PI_D_OUT is registered on rd_rise:
    - DATA: rdata.
    - STATUS: {overflow, err, rd_valid, PI_TXN_IN_PROGRESS, 8'd0, count[3:0]}.
  - Reading DATA clears rd_valid on the same cycle.
- Downstream handshake:
  - OP_VALID = (count != 0) && !outstanding; OP_* fields always reflect the FIFO head.
  - OP_ACK while OP_VALID: pop head, outstanding <= 1. OP_ACK while !OP_VALID is ignored.
  - OP_DONE while outstanding: outstanding <= 0. If the popped op was a read: rdata <= OP_RDATA, rd_valid <= 1. OP_DONE while !outstanding is ignored.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, both pointers advance; allowed even when full, since the pop frees the slot first.
  - OP_DONE and a Pi DATA read in the same cycle: the rd_valid set from OP_DONE wins.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH and is PTR_W+1 bits wide.
- PI_TXN_IN_PROGRESS is registered: (count != 0) || outstanding, one cycle latency.
- Reset mid-operation: everything is discarded and no OP_VALID is asserted until a new push.

Optional Feature:
PI_QUEUE_BERR_EN
- Defined: OP_DONE with OP_BERR=1 sets err, sets rdata = 16'hFFFF for reads, and flushes all queued entries (count <= 0, rd_ptr <= wr_ptr) on the same cycle. Pushes landing in the flush cycle are dropped.
- Undefined: OP_BERR is ignored and the err bit always reads 0.

Test Plan:
- Write DATA=0x1234, ADDR_LO=0x0000, ADDR_HI=0x0000 (word write) -> OP_VALID within 2 cycles of the wr_rise decode; OP_ADDR=0x000000, OP_WDATA=0x1234, UDS_n=LDS_n=0, OP_RW=0.
- Byte read at address 0x00BFE001 (ADDR_LO=0xE001, ADDR_HI=0x03BF) -> OP_UDS_n=1, OP_LDS_n=0. After OP_ACK, then OP_DONE with OP_RDATA=0x00A5: Pi DATA read returns 0x00A5 and STATUS bit13 (rd_valid) clears.
- Push 5 writes with DEPTH=4 and no ACK -> STATUS count=4, bit15 overflow=1. Writing STATUS=0x8000 clears overflow.
- Hold FIFO full, push and OP_ACK in the same cycle -> count stays 4, no overflow, new entry reaches the head after 3 more pops.
- PI_RST_n low while outstanding with 3 queued -> OP_VALID=0, count=0, PI_TXN_IN_PROGRESS=0 immediately (asynchronous).
- With PI_QUEUE_BERR_EN: 3 queued, OP_DONE with OP_BERR=1 -> err=1, count=0, read data 0xFFFF; without the macro, err stays 0 and count=2.
